scan_chain_ctrl: RTL and testbench
==================================

// Module: scan_chain_ctrl
// PURPOSE
//  Sequences one scan chain of mux-D scan flops (D/SCD/SCE, rising-edge CLK).
//  Per test: shifts a parallel pattern into the chain, runs capture cycles, then unloads the chain into a parallel result.
//  Sits between a test host (valid/ready) and the chain's SCE/SCD/clock-enable/scan-out pins.
// PARAMETERS
//  CHAIN_LEN   16  flops in the chain; >=2
//  CAP_CYCLES  1   functional capture clocks per test (SCE=0); >=1
// PORTS
//  CLK           in   1          single clock; controller and chain clock gate share it
//  RESET_B       in   1          asynchronous, active-low reset
//  START_VALID   in   1          host requests a test
//  START_READY   out  1          high only in IDLE; test accepted on VALID&READY edge
//  PAT_IN        in   CHAIN_LEN  pattern, sampled at acceptance; PAT_IN[0] ends at chain tail
//  ABORT         in   1          synchronous cancel, any state
//  SCE           out  1          scan enable to every chain flop
//  SCD           out  1          serial data to chain head
//  CHAIN_CLK_EN  out  1          clock-gate enable for chain CLK
//  SCAN_OUT      in   1          chain tail Q
//  RESULT        out  CHAIN_LEN  unloaded data; RESULT[0] = tail value right after capture
//  RESULT_VALID  out  1          result held until RESULT_READY
//  RESULT_READY  in   1          host consumes result
//  BUSY          out  1          state != IDLE
// BEHAVIOUR
//  - Reset (async): state IDLE; SCE=0, SCD=0, CHAIN_CLK_EN=0, RESULT=0, RESULT_VALID=0, BUSY=0, START_READY=1. Chain contents are undefined after reset.
//  - SCE/SCD/CHAIN_CLK_EN are registered and change only on CLK rising edges (glitch-free).
//  - FSM: IDLE -> LOAD -> CAPTURE -> UNLOAD -> DONE -> IDLE.
//  - IDLE: SCE=0, CHAIN_CLK_EN=0. Leaves on START_VALID&START_READY; latches PAT_IN into shift register.
//  - LOAD: exactly CHAIN_LEN cycles; cycle k drives SCE=1, SCD=PAT_IN[k], CHAIN_CLK_EN=1.
//  - CAPTURE: exactly CAP_CYCLES cycles; SCE=0, SCD=0, CHAIN_CLK_EN=1.
//  - UNLOAD: exactly CHAIN_LEN cycles; SCE=1, SCD=0 (zero fill), CHAIN_CLK_EN=1.
//    In cycle k, SCAN_OUT is sampled into RESULT[k] on the same edge that shifts the chain.
//  - DONE: SCE=0, CHAIN_CLK_EN=0, RESULT_VALID=1; RESULT is stable.
//    On RESULT_READY: RESULT_VALID drops next cycle, FSM returns to IDLE. RESULT_READY is ignored outside DONE.
//  - Latency: acceptance edge -> RESULT_VALID high = 2*CHAIN_LEN+CAP_CYCLES+1 cycles.
//  - Throughput: next acceptance is possible one cycle after the RESULT_READY handshake.
//  - ABORT: wins over every other input. Next cycle: IDLE, CHAIN_CLK_EN=0, SCE=0, RESULT_VALID=0. RESULT keeps its partial value. ABORT in IDLE is a no-op.
//  - START_VALID held during BUSY is ignored until IDLE (no queueing); PAT_IN is sampled only at acceptance.
//  - A single down-counter, width $clog2(max(CHAIN_LEN,CAP_CYCLES)+1), is reloaded on each state entry; the state exits when the count reaches 1.
//  - RESET_B assertion mid-test forces reset values immediately; no result is produced.
// CONFIGURATION
//  SCAN_CTRL_PARITY_EN defined:
//    - adds output RESULT_PAR (1 bit) = XOR of all RESULT bits, accumulated serially during UNLOAD;
//    - valid with RESULT_VALID; reset 0; cleared on acceptance.
//  SCAN_CTRL_PARITY_EN undefined:
//    - port and accumulator are absent; all other behaviour is identical.
// STRUCTURE
//  Package scan_ctrl_pkg:
//    - state enum (IDLE, LOAD, CAPTURE, UNLOAD, DONE);
//    - localparam helper function for counter width.
//  One sub-module, scan_shift_reg: CHAIN_LEN-bit parallel-load / serial-out / serial-in register, shared by LOAD and UNLOAD.
//  The FSM and the counter stay in the top module.
// TESTING (bench models the chain as a CHAIN_LEN-bit mux-D scan register on gated CLK)
//  1. CHAIN_LEN=16, CAP_CYCLES=1, chain D=~Q, PAT_IN=16'hA5C3 -> RESULT=16'h5A3C.
//     RESULT_VALID rises exactly 34 cycles after acceptance.
//  2. Chain D=Q (hold), PAT_IN=16'h0001 -> RESULT=16'h0001.
//     SCE=1 for exactly 16 LOAD + 16 UNLOAD cycles; CHAIN_CLK_EN=0 in IDLE and DONE.
//  3. CAP_CYCLES=3, D=~Q, PAT_IN=16'hFFFF -> RESULT=16'h0000 (odd inversions), latency 36 cycles.
//  4. ABORT on 5th LOAD cycle -> IDLE next cycle, SCE=0, no RESULT_VALID.
//     A new START then completes normally.
//  5. RESULT_READY held low 10 cycles in DONE -> RESULT/RESULT_VALID stable; START_READY=0 throughout.
//     START_READY=1 one cycle after the READY handshake.
//  6. RESET_B low during UNLOAD -> all outputs at reset values asynchronously (before the next edge).
//     With SCAN_CTRL_PARITY_EN, case 1 gives RESULT_PAR=0.

Source files
------------

// File: rtl/scan_ctrl_pkg.sv
// Shared types for the scan chain controller: FSM state encoding and the
// down-counter width helper.
package scan_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCapture,
        StUnload,
        StDone
    } scan_state_e;

    // Counter must hold the longest phase length (load/unload or capture).
    function automatic int unsigned cnt_width(input int unsigned chain_len,
                                              input int unsigned cap_cycles);
        int unsigned longest;
        longest = (chain_len > cap_cycles) ? chain_len : cap_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// Parallel-load / serial-out / serial-in register shared by the LOAD and
// UNLOAD phases; shifts toward bit 0 and fills from the top.
module scan_shift_reg #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic             sin,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= par_in;
        end else if (shift) begin
            data_q <= {sin, data_q[WIDTH-1:1]};
        end
    end

    assign q = data_q;

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain sequencer: load pattern, capture, unload result, hand back to host.
// Optional feature macro: SCAN_CTRL_PARITY_EN adds RESULT_PAR (XOR of RESULT).
module scan_chain_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int unsigned CHAIN_LEN  = 16,
    parameter int unsigned CAP_CYCLES = 1
) (
    input  logic                 CLK,
    input  logic                 RESET_B,
    input  logic                 START_VALID,
    output logic                 START_READY,
    input  logic [CHAIN_LEN-1:0] PAT_IN,
    input  logic                 ABORT,
    output logic                 SCE,
    output logic                 SCD,
    output logic                 CHAIN_CLK_EN,
    input  logic                 SCAN_OUT,
    output logic [CHAIN_LEN-1:0] RESULT,
    output logic                 RESULT_VALID,
    input  logic                 RESULT_READY,
`ifdef SCAN_CTRL_PARITY_EN
    output logic                 RESULT_PAR,
`endif
    output logic                 BUSY
);

    localparam int unsigned CNT_W = cnt_width(CHAIN_LEN, CAP_CYCLES);
    localparam logic [CNT_W-1:0] LEN_CNT = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CAP_CNT = CNT_W'(CAP_CYCLES);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    scan_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sce_q, sce_d;
    logic                 scd_q, scd_d;
    logic                 en_q, en_d;
    logic                 valid_q, valid_d;
    logic                 sr_load, sr_shift, sr_sin;
    logic [CHAIN_LEN-1:0] sr_q;
    logic                 cnt_last;

    assign cnt_last = (cnt_q == ONE_CNT);
    assign sr_sin   = (state_q == StUnload) ? SCAN_OUT : 1'b0;

    scan_shift_reg #(
        .WIDTH (CHAIN_LEN)
    ) u_shift_reg (
        .clk    (CLK),
        .rst_n  (RESET_B),
        .load   (sr_load),
        .shift  (sr_shift),
        .sin    (sr_sin),
        .par_in (PAT_IN),
        .q      (sr_q)
    );

    // Pin values are computed for the state being entered, so SCE/SCD/CHAIN_CLK_EN
    // come straight from flops and line up with the FSM state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sce_d    = 1'b0;
        scd_d    = 1'b0;
        en_d     = 1'b0;
        valid_d  = 1'b0;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        if (ABORT) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (START_VALID) begin
                        state_d = StLoad;
                        cnt_d   = LEN_CNT;
                        sr_load = 1'b1;
                        sce_d   = 1'b1;
                        scd_d   = PAT_IN[0];
                        en_d    = 1'b1;
                    end
                end
                StLoad: begin
                    sr_shift = 1'b1;
                    en_d     = 1'b1;
                    if (cnt_last) begin
                        state_d = StCapture;
                        cnt_d   = CAP_CNT;
                    end else begin
                        cnt_d = cnt_q - ONE_CNT;
                        sce_d = 1'b1;
                        scd_d = sr_q[1];
                    end
                end
                StCapture: begin
                    en_d  = 1'b1;
                    sce_d = 1'b1;
                    if (cnt_last) begin
                        state_d = StUnload;
                        cnt_d   = LEN_CNT;
                    end else begin
                        cnt_d = cnt_q - ONE_CNT;
                        sce_d = 1'b0;
                    end
                end
                StUnload: begin
                    sr_shift = 1'b1;
                    if (cnt_last) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q - ONE_CNT;
                        sce_d = 1'b1;
                        en_d  = 1'b1;
                    end
                end
                StDone: begin
                    // RESULT settles on DONE entry; VALID follows one cycle later.
                    valid_d = 1'b1;
                    if (valid_q && RESULT_READY) begin
                        state_d = StIdle;
                        valid_d = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sce_q   <= 1'b0;
            scd_q   <= 1'b0;
            en_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sce_q   <= sce_d;
            scd_q   <= scd_d;
            en_q    <= en_d;
            valid_q <= valid_d;
        end
    end

`ifdef SCAN_CTRL_PARITY_EN
    logic par_q, par_d;

    always_comb begin
        par_d = par_q;
        if (!ABORT) begin
            if (state_q == StIdle && START_VALID) begin
                par_d = 1'b0;
            end else if (state_q == StUnload) begin
                par_d = par_q ^ SCAN_OUT;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign RESULT_PAR = par_q;
`endif

    assign START_READY  = (state_q == StIdle);
    assign BUSY         = (state_q != StIdle);
    assign SCE          = sce_q;
    assign SCD          = scd_q;
    assign CHAIN_CLK_EN = en_q;
    assign RESULT       = sr_q;
    assign RESULT_VALID = valid_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: two instances (1 and 3 capture cycles) each driving
// a modelled mux-D scan chain; results checked against a pattern-level model.
module tb_scan_chain_ctrl;

    localparam int N = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         start_valid [2];
    logic         start_ready [2];
    logic         abort_s     [2];
    logic         sce         [2];
    logic         scd         [2];
    logic         en          [2];
    logic         scan_out    [2];
    logic         result_valid[2];
    logic         result_ready[2];
    logic         busy        [2];
    logic [N-1:0] pat_in      [2];
    logic [N-1:0] result      [2];
    logic [N-1:0] chain       [2];
    logic         dmode       [2];
`ifdef SCAN_CTRL_PARITY_EN
    logic         result_par  [2];
`endif

    int tests = 0;
    int fails = 0;

    int           sce_cnt [2];
    int           en_cnt  [2];
    int           en_bad  [2];
    int           scd_n   [2];
    logic [63:0]  scd_bits[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        scan_chain_ctrl #(
            .CHAIN_LEN  (N),
            .CAP_CYCLES ((g == 0) ? 1 : 3)
        ) dut (
            .CLK          (clk),
            .RESET_B      (rst_n),
            .START_VALID  (start_valid[g]),
            .START_READY  (start_ready[g]),
            .PAT_IN       (pat_in[g]),
            .ABORT        (abort_s[g]),
            .SCE          (sce[g]),
            .SCD          (scd[g]),
            .CHAIN_CLK_EN (en[g]),
            .SCAN_OUT     (scan_out[g]),
            .RESULT       (result[g]),
            .RESULT_VALID (result_valid[g]),
            .RESULT_READY (result_ready[g]),
`ifdef SCAN_CTRL_PARITY_EN
            .RESULT_PAR   (result_par[g]),
`endif
            .BUSY         (busy[g])
        );

        // Scan chain: head at bit 0, tail at bit N-1; D is Q (hold) or ~Q.
        always @(posedge clk) begin
            if (en[g]) begin
                if (sce[g]) chain[g] <= {chain[g][N-2:0], scd[g]};
                else        chain[g] <= dmode[g] ? ~chain[g] : chain[g];
            end
        end
        assign scan_out[g] = chain[g][N-1];

        always @(negedge clk) begin
            if (sce[g]) begin
                if (scd_n[g] < 64) scd_bits[g][scd_n[g][5:0]] = scd[g];
                scd_n[g]++;
                sce_cnt[g]++;
            end
            if (en[g]) en_cnt[g]++;
            if (en[g] && (start_ready[g] || result_valid[g])) en_bad[g]++;
        end
    end

    function automatic int cap_of(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    // Each capture applies the chain's D function once; unload returns bits in load order.
    function automatic logic [N-1:0] ref_result(input logic [N-1:0] pat, input logic inv,
                                                input int cap);
        return (inv && (cap % 2 == 1)) ? ~pat : pat;
    endfunction

    task automatic clear_mon(input int u);
        sce_cnt[u]  = 0;
        en_cnt[u]   = 0;
        en_bad[u]   = 0;
        scd_n[u]    = 0;
        scd_bits[u] = '0;
    endtask

    task automatic do_test(input int u, input logic [N-1:0] pat, input logic inv,
                           input string name);
        int           lat;
        int           cap;
        logic [N-1:0] exp;
        cap = cap_of(u);
        exp = ref_result(pat, inv, cap);
        @(posedge clk); #1;
        dmode[u] = inv;
        clear_mon(u);
        start_valid[u] = 1'b1;
        pat_in[u]      = pat;
        @(posedge clk); #1;
        start_valid[u] = 1'b0;
        pat_in[u]      = N'($urandom);
        tests++;
        if (busy[u] !== 1'b1) begin
            fails++;
            $display("FAIL %s accept: busy=%b expected 1", name, busy[u]);
        end
        lat = 0;
        while (result_valid[u] !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        tests++;
        if (lat != 2 * N + cap + 1) begin
            fails++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, 2 * N + cap + 1);
        end
        tests++;
        if (result[u] !== exp) begin
            fails++;
            $display("FAIL %s result: got %h expected %h", name, result[u], exp);
        end
        tests++;
        if (sce_cnt[u] != 2 * N || en_cnt[u] != 2 * N + cap || en_bad[u] != 0) begin
            fails++;
            $display("FAIL %s pin counts: sce=%0d en=%0d en_idle=%0d expected %0d %0d 0",
                     name, sce_cnt[u], en_cnt[u], en_bad[u], 2 * N, 2 * N + cap);
        end
        tests++;
        if (scd_bits[u][N-1:0] !== pat || scd_bits[u][2*N-1:N] !== '0) begin
            fails++;
            $display("FAIL %s scd stream: got %h expected %h", name, scd_bits[u][2*N-1:0],
                     {{N{1'b0}}, pat});
        end
`ifdef SCAN_CTRL_PARITY_EN
        tests++;
        if (result_par[u] !== ^exp) begin
            fails++;
            $display("FAIL %s parity: got %b expected %b", name, result_par[u], ^exp);
        end
`endif
        result_ready[u] = 1'b1;
        @(posedge clk); #1;
        result_ready[u] = 1'b0;
        tests++;
        if (result_valid[u] !== 1'b0 || start_ready[u] !== 1'b1) begin
            fails++;
            $display("FAIL %s handshake: valid=%b ready=%b expected 0 1", name,
                     result_valid[u], start_ready[u]);
        end
    endtask

    task automatic test_reset();
        for (int u = 0; u < 2; u++) begin
            tests++;
            if (sce[u] !== 1'b0 || scd[u] !== 1'b0 || en[u] !== 1'b0 || busy[u] !== 1'b0 ||
                result[u] !== '0 || result_valid[u] !== 1'b0 || start_ready[u] !== 1'b1) begin
                fails++;
                $display("FAIL reset u%0d: sce=%b scd=%b en=%b busy=%b res=%h val=%b rdy=%b",
                         u, sce[u], scd[u], en[u], busy[u], result[u], result_valid[u],
                         start_ready[u]);
            end
        end
    endtask

    task automatic test_directed();
        do_test(0, 16'hA5C3, 1'b1, "invert_a5c3");
        do_test(0, 16'h0001, 1'b0, "hold_0001");
        do_test(1, 16'hFFFF, 1'b1, "cap3_ffff");
    endtask

    task automatic test_abort();
        @(posedge clk); #1;
        dmode[0] = 1'b1;
        start_valid[0] = 1'b1;
        pat_in[0] = 16'h1234;
        @(posedge clk); #1;
        start_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1 abort_s[0] = 1'b1;
        @(posedge clk); #1;
        abort_s[0] = 1'b0;
        tests++;
        if (busy[0] !== 1'b0 || sce[0] !== 1'b0 || en[0] !== 1'b0 || result_valid[0] !== 1'b0) begin
            fails++;
            $display("FAIL abort_load: busy=%b sce=%b en=%b valid=%b expected 0", busy[0],
                     sce[0], en[0], result_valid[0]);
        end
        // ABORT alongside START_VALID in idle must block acceptance.
        abort_s[0] = 1'b1;
        start_valid[0] = 1'b1;
        @(posedge clk); #1;
        abort_s[0] = 1'b0;
        start_valid[0] = 1'b0;
        clear_mon(0);
        repeat (40) @(posedge clk);
        #1;
        tests++;
        if (busy[0] !== 1'b0 || result_valid[0] !== 1'b0 || en_cnt[0] != 0) begin
            fails++;
            $display("FAIL abort_idle: busy=%b valid=%b en_cycles=%0d expected 0 0 0",
                     busy[0], result_valid[0], en_cnt[0]);
        end
        do_test(0, 16'h1234, 1'b1, "after_abort");
    endtask

    task automatic test_done_hold();
        logic [N-1:0] p1, p2, snap;
        int           bad;
        int           lat;
        p1 = N'($urandom);
        p2 = N'($urandom);
        @(posedge clk); #1;
        dmode[0] = 1'b1;
        start_valid[0] = 1'b1;
        pat_in[0] = p1;
        @(posedge clk); #1;
        pat_in[0] = p2;   // START_VALID stays high: must not queue a second test
        lat = 0;
        while (result_valid[0] !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        snap = result[0];
        tests++;
        if (snap !== ~p1) begin
            fails++;
            $display("FAIL hold_first: got %h expected %h", snap, ~p1);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (result[0] !== snap || result_valid[0] !== 1'b1 || start_ready[0] !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL done_hold: unstable cycles=%0d expected 0", bad);
        end
        result_ready[0] = 1'b1;
        @(posedge clk); #1;
        result_ready[0] = 1'b0;
        tests++;
        if (start_ready[0] !== 1'b1 || result_valid[0] !== 1'b0) begin
            fails++;
            $display("FAIL done_release: ready=%b valid=%b expected 1 0", start_ready[0],
                     result_valid[0]);
        end
        @(posedge clk); #1;
        start_valid[0] = 1'b0;
        tests++;
        if (busy[0] !== 1'b1) begin
            fails++;
            $display("FAIL back_to_back accept: busy=%b expected 1", busy[0]);
        end
        lat = 0;
        while (result_valid[0] !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        tests++;
        if (result[0] !== ~p2 || lat != 2 * N + 2) begin
            fails++;
            $display("FAIL back_to_back: result=%h lat=%0d expected %h %0d", result[0], lat,
                     ~p2, 2 * N + 2);
        end
        result_ready[0] = 1'b1;
        @(posedge clk); #1;
        result_ready[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        dmode[0] = 1'b0;
        start_valid[0] = 1'b1;
        pat_in[0] = 16'hBEEF;
        @(posedge clk); #1;
        start_valid[0] = 1'b0;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if (sce[0] !== 1'b0 || scd[0] !== 1'b0 || en[0] !== 1'b0 || busy[0] !== 1'b0 ||
            result[0] !== '0 || result_valid[0] !== 1'b0 || start_ready[0] !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid: sce=%b scd=%b en=%b busy=%b res=%h val=%b rdy=%b",
                     sce[0], scd[0], en[0], busy[0], result[0], result_valid[0],
                     start_ready[0]);
        end
        #2 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        tests++;
        if (result_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid after: valid=%b busy=%b expected 0 0", result_valid[0],
                     busy[0]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            do_test(int'($urandom_range(1, 0)), N'($urandom), 1'($urandom), "random");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            start_valid[u]  = 1'b0;
            abort_s[u]      = 1'b0;
            result_ready[u] = 1'b0;
            pat_in[u]       = '0;
            dmode[u]        = 1'b0;
            chain[u]        = N'($urandom);
            clear_mon(u);
        end
        #12;
        test_reset();
        #4 rst_n = 1'b1;
        test_directed();
        test_abort();
        test_done_hold();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
